// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// master drives start/bin_in; slave (the converter) returns busy/done/bcd_out.
interface bin_to_bcd_seq_if #(
    parameter int unsigned N_BITS = 26
);
    logic              start;
    logic [N_BITS-1:0] bin_in;
    logic              busy;
    logic              done;
    logic [31:0]       bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, result
// latched into bcd_out with a single-cycle done pulse.
module bin_to_bcd_seq #(
    parameter int unsigned N_BITS = 26,
    parameter int unsigned DIGITS = 8
) (
    input logic             clock,
    input logic             reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [N_BITS-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        bcd_q, bcd_d;
    logic               done_q, done_d;

    // Add-3 correction per digit, no carry between digits
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_d     = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(N_BITS);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], bin_q[N_BITS-1]};
                bin_d     = {bin_q[N_BITS-2:0], 1'b0};
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, ignored starts,
// reset abort and back-to-back conversions.
module tb_bin_to_bcd_seq;
    localparam int unsigned N_BITS = 26;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;
    logic [31:0] prev;

    bin_to_bcd_seq_if #(.N_BITS(N_BITS)) bus ();

    bin_to_bcd_seq #(
        .N_BITS(N_BITS),
        .DIGITS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One conversion; optional extra start pulse at glitch_at cycles after acceptance
    task automatic conv(input string tag, input logic [25:0] val, input logic [31:0] exp,
                        input int glitch_at, input logic [25:0] glitch_val);
        int n, done_n, dones, busy_n;
        logic held;
        bus.bin_in = val;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.bin_in = ~val;
        n = 0; done_n = -1; dones = 0; busy_n = 0; held = 1'b1;
        while (n < int'(N_BITS) + 6) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                dones++;
                if (done_n < 0) done_n = n;
            end
            if (done_n < 0 && bus.bcd_out !== prev) held = 1'b0;
            if (n == glitch_at) begin
                bus.start  = 1'b1;
                bus.bin_in = glitch_val;
            end else begin
                bus.start  = 1'b0;
            end
            step();
            n++;
        end
        check({tag, "_latency"}, done_n, N_BITS + 1);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_busy_cycles"}, busy_n, N_BITS + 1);
        check({tag, "_held_before_done"}, {31'd0, held}, 32'd1);
        check({tag, "_result"}, bus.bcd_out, exp);
        prev = exp;
    endtask

    initial begin
        int n, dones, first_n, second_n;
        logic ok;
        logic [31:0] first_bcd, second_bcd;
        compared   = 0;
        mismatched = 0;
        prev       = '0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        reset      = 1'b1;
        #2 reset   = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bcd", bus.bcd_out, 32'h0000_0000);
        step();
        step();
        reset = 1'b1;

        conv("zero", 26'd0, 32'h0000_0000, -1, 26'd0);
        conv("mid", 26'd12_345_678, 32'h1234_5678, -1, 26'd0);
        conv("max", 26'd67_108_863, 32'h6710_8863, -1, 26'd0);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        check("max_digits_legal", {31'd0, ok}, 32'd1);
        conv("ignore_start", 26'd999, 32'h0000_0999, 10, 26'd5);

        conv("pre_abort", 26'd42, 32'h0000_0042, -1, 26'd0);
        bus.bin_in = 26'd77;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        repeat (15) step();
        #2 reset = 1'b0;
        #1;
        check("abort_bcd", bus.bcd_out, 32'h0000_0000);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        step();
        step();
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 35; i++) begin
            if (bus.done) dones++;
            step();
        end
        check("abort_no_done", dones, 0);
        check("abort_bcd_held", bus.bcd_out, 32'h0000_0000);
        prev = '0;

        bus.bin_in = 26'd1;
        bus.start  = 1'b1;
        step();
        bus.bin_in = 26'd2;
        n = 0; dones = 0; first_n = -1; second_n = -1;
        first_bcd = '0; second_bcd = '0;
        while (n < 62) begin
            if (bus.done) begin
                dones++;
                if (first_n < 0) begin
                    first_n   = n;
                    first_bcd = bus.bcd_out;
                end else if (second_n < 0) begin
                    second_n   = n;
                    second_bcd = bus.bcd_out;
                end
            end
            if (n == int'(N_BITS) + 2) bus.start = 1'b0;
            step();
            n++;
        end
        check("b2b_first_time", first_n, N_BITS + 1);
        check("b2b_first_bcd", first_bcd, 32'h0000_0001);
        check("b2b_second_time", second_n, 2 * N_BITS + 3);
        check("b2b_second_bcd", second_bcd, 32'h0000_0002);
        check("b2b_done_count", dones, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
